write_back_unit: RTL and testbench

Registered, buffered write-back stage that sits between the memory stage and the register-file write port. Accepts one retiring instruction per cycle over a valid/ready handshake, selects and load-aligns the write-back value, and queues it in a small FIFO. It drains the FIFO to the register file whenever the write port is granted. Optionally forwards queued results to decode-stage operand reads.

---
 rtl/write_back_unit.sv | 214 +++++++++++++++++++++
 tb/tb_write_back_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_unit.sv
// write_back_unit
//
// Buffered write-back stage between the memory stage and the register-file
// write port. Each retiring instruction arrives over a valid/ready handshake.
// The unit picks the write-back value: the return address, the ALU/memory
// result, or an aligned and extended load. Instructions that write a real
// register are queued in a small circular FIFO, and the FIFO head is retired
// whenever the register file grants the write port.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   - queued entries are forwarded to the two decode operand ports
//   undefined - no comparators; fwd_hit*/fwd_data* are tied to 0
//
// Encodings:
//   in_wb_ctrl (write_back_op_t): 2'd0 NO_WRITE_BACK, 2'd1 WRITE_BACK_PC,
//                                 2'd2 WRITE_BACK_OUT, 2'd3 treated as no write
//   reg_op (reg_file_op_t):       1'b0 NO_REG_DATA, 1'b1 WRITE_REG_DATA
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid / in_ready          accept handshake (in_ready = !full)
//   in_pc_4, in_mem_out          candidate write-back values
//   in_wb_ctrl, in_is_load       value select
//   in_funct3, in_byte_off       load size/sign and byte offset
//   in_rd                        destination register (x0 is dropped)
//   reg_op, reg_rd,
//   reg_write_data               register-file write request (queue head)
//   rf_grant                     register file consumes the head this cycle
//   fwd_rs1/2 -> fwd_hit1/2,
//   fwd_data1/2                  youngest queued value for a source register
//   count                        queue occupancy
module write_back_unit #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int RADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc_4,
    input  logic [XLEN-1:0]           in_mem_out,
    input  logic [1:0]                in_wb_ctrl,
    input  logic                      in_is_load,
    input  logic [2:0]                in_funct3,
    input  logic [$clog2(XLEN/8)-1:0] in_byte_off,
    input  logic [RADDR_W-1:0]        in_rd,
    output logic                      reg_op,
    output logic [RADDR_W-1:0]        reg_rd,
    output logic [XLEN-1:0]           reg_write_data,
    input  logic                      rf_grant,
    input  logic [RADDR_W-1:0]        fwd_rs1,
    input  logic [RADDR_W-1:0]        fwd_rs2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [XLEN-1:0]           fwd_data1,
    output logic [XLEN-1:0]           fwd_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] WRITE_BACK_PC  = 2'd1;
    localparam logic [1:0] WRITE_BACK_OUT = 2'd2;

    localparam logic NO_REG_DATA    = 1'b0;
    localparam logic WRITE_REG_DATA = 1'b1;

    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [XLEN-1:0]    mem_data_q [DEPTH];
    logic [RADDR_W-1:0] mem_rd_q   [DEPTH];

    logic               nonempty;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic [XLEN-1:0]    wb_val;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    sext_w;
    logic [XLEN-1:0]    load_val;

    // ------------------------------------------------------------------
    // Load alignment. A misaligned offset is not trapped; the shifted
    // data is used as-is.
    // ------------------------------------------------------------------
    assign shifted = in_mem_out >> {in_byte_off, 3'b000};
    assign sext_w  = XLEN'(signed'(shifted[31:0]));

    always_comb begin
        load_val = sext_w;
        case (in_funct3)
            3'b000:  load_val = XLEN'(signed'(shifted[7:0]));
            3'b001:  load_val = XLEN'(signed'(shifted[15:0]));
            3'b010:  load_val = sext_w;
            3'b011:  load_val = (XLEN == 64) ? shifted : sext_w;
            3'b100:  load_val = XLEN'(shifted[7:0]);
            3'b101:  load_val = XLEN'(shifted[15:0]);
            3'b110:  load_val = XLEN'(shifted[31:0]);
            default: load_val = in_mem_out;
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        wb_val = '0;
        case (in_wb_ctrl)
            WRITE_BACK_PC: begin
                wr_en  = 1'b1;
                wb_val = in_pc_4;
            end
            WRITE_BACK_OUT: begin
                wr_en  = 1'b1;
                wb_val = in_is_load ? load_val : in_mem_out;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue control. in_ready comes only from the registered count, so a
    // slot freed by rf_grant becomes usable one cycle later.
    // ------------------------------------------------------------------
    assign nonempty = (count_q != '0);
    assign in_ready = (count_q != CNT_W'(DEPTH));

    // Writes to x0, and instructions with no write-back, are consumed
    // without being enqueued.
    assign push = in_valid && in_ready && wr_en && (in_rd != '0);
    assign pop  = rf_grant && nonempty;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // The storage itself is not reset: every reader is qualified by
    // count_q, so clearing the count is enough to invalidate it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wptr_q] <= wb_val;
            mem_rd_q[wptr_q]   <= in_rd;
        end
    end

    assign reg_op         = nonempty ? WRITE_REG_DATA : NO_REG_DATA;
    assign reg_rd         = nonempty ? mem_rd_q[rptr_q] : '0;
    assign reg_write_data = nonempty ? mem_data_q[rptr_q] : '0;
    assign count          = count_q;

    // ------------------------------------------------------------------
    // Forwarding. The loop walks from oldest to youngest, so a later
    // match overrides an earlier one. An entry being accepted this cycle
    // is not yet in the queue. An entry being popped this cycle is still
    // counted, so it remains visible.
    // ------------------------------------------------------------------
`ifdef WB_FORWARD_EN
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if ((fwd_rs1 != '0) && (mem_rd_q[idx] == fwd_rs1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem_data_q[idx];
                end
                if ((fwd_rs2 != '0) && (mem_rd_q[idx] == fwd_rs2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem_data_q[idx];
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_rs1, fwd_rs2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
module tb_write_back_unit;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 2;
    localparam int RADDR_W = 5;

`ifdef WB_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    localparam logic [1:0] NO_WB  = 2'd0;
    localparam logic [1:0] WB_PC  = 2'd1;
    localparam logic [1:0] WB_OUT = 2'd2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc_4;
    logic [XLEN-1:0]    in_mem_out;
    logic [1:0]         in_wb_ctrl;
    logic               in_is_load;
    logic [2:0]         in_funct3;
    logic [1:0]         in_byte_off;
    logic [RADDR_W-1:0] in_rd;
    logic               reg_op;
    logic [RADDR_W-1:0] reg_rd;
    logic [XLEN-1:0]    reg_write_data;
    logic               rf_grant;
    logic [RADDR_W-1:0] fwd_rs1;
    logic [RADDR_W-1:0] fwd_rs2;
    logic               fwd_hit1;
    logic               fwd_hit2;
    logic [XLEN-1:0]    fwd_data1;
    logic [XLEN-1:0]    fwd_data2;
    logic [1:0]         count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_back_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_4(in_pc_4), .in_mem_out(in_mem_out),
        .in_wb_ctrl(in_wb_ctrl), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_byte_off(in_byte_off), .in_rd(in_rd),
        .reg_op(reg_op), .reg_rd(reg_rd), .reg_write_data(reg_write_data),
        .rf_grant(rf_grant),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    // Drive one instruction onto the input bus (no checking).
    task automatic drive_in(input logic v, input logic [1:0] ctrl, input logic ld,
                            input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] pc4, input logic [31:0] mo,
                            input logic [4:0] rd);
        in_valid    = v;
        in_wb_ctrl  = ctrl;
        in_is_load  = ld;
        in_funct3   = f3;
        in_byte_off = off;
        in_pc_4     = pc4;
        in_mem_out  = mo;
        in_rd       = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_in(1'b0, NO_WB, 1'b0, 3'b0, 2'b0, 32'h0, 32'h0, 5'd0);
        rf_grant = 1'b0;
        fwd_rs1  = 5'd0;
        fwd_rs2  = 5'd0;
        repeat (2) @(negedge clk);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (reg_op !== 1'b0) begin errors++; $display("FAIL reset_reg_op: got %b want 0", reg_op); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (reg_rd !== 5'd0) begin errors++; $display("FAIL reset_reg_rd: got %0d want 0", reg_rd); end
        checks++; if (reg_write_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", reg_write_data); end
        checks++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit: got %b want 00", {fwd_hit1, fwd_hit2}); end
        checks++; if ({fwd_data1, fwd_data2} !== 64'h0) begin errors++; $display("FAIL reset_fwd_data: got %h want 0", {fwd_data1, fwd_data2}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_align();
        logic [2:0]  f3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111, 3'b000};
        logic [1:0]  off [9] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3};
        logic [31:0] mo  [9] = '{32'h0080_1234, 32'h0080_1234, 32'h0000_8001, 32'h9ABC_0000,
                                 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8012_3456};
        logic [31:0] exp [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_9ABC,
                                 32'h00DE_ADBE, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FF80};
        for (int i = 0; i < 9; i++) begin
            drive_in(1'b1, WB_OUT, 1'b1, f3[i], off[i], 32'h0, mo[i], 5'd5);
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (reg_op !== 1'b1) begin errors++; $display("FAIL load_reg_op[%0d]: got %b want 1", i, reg_op); end
            checks++; if (reg_rd !== 5'd5) begin errors++; $display("FAIL load_reg_rd[%0d]: got %0d want 5", i, reg_rd); end
            checks++; if (reg_write_data !== exp[i]) begin errors++; $display("FAIL load_data[%0d]: got %h want %h", i, reg_write_data, exp[i]); end
            rf_grant = 1'b1;
            @(negedge clk);
            rf_grant = 1'b0;
            checks++; if (count !== 2'd0) begin errors++; $display("FAIL load_drain[%0d]: got %0d want 0", i, count); end
        end
        // Non-load result passes through unchanged.
        drive_in(1'b1, WB_OUT, 1'b0, 3'b000, 2'd3, 32'h0, 32'h1234_5678, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (reg_write_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_out: got %h want 12345678", reg_write_data); end
        rf_grant = 1'b1;
        @(negedge clk);
        rf_grant = 1'b0;
    endtask

    task automatic test_pc_and_drop();
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h104, 32'hFFFF_FFFF, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (reg_write_data !== 32'h104) begin errors++; $display("FAIL pc_data: got %h want 104", reg_write_data); end
        checks++; if (reg_rd !== 5'd1) begin errors++; $display("FAIL pc_rd: got %0d want 1", reg_rd); end
        rf_grant = 1'b1;
        @(negedge clk);
        rf_grant = 1'b0;
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h104, 32'h0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL x0_drop_count: got %0d want 0", count); end
        checks++; if (reg_op !== 1'b0) begin errors++; $display("FAIL x0_drop_reg_op: got %b want 0", reg_op); end
        drive_in(1'b1, NO_WB, 1'b0, 3'b0, 2'd0, 32'h200, 32'h300, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL no_wb_drop_count: got %0d want 0", count); end
    endtask

    task automatic test_back_pressure();
        rf_grant = 1'b0;
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'hA0, 32'h0, 5'd2);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_at1: got %b want 1", in_ready); end
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'hB0, 32'h0, 5'd3);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'hC0, 32'h0, 5'd4);
        @(negedge clk);
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_third_blocked: got %0d want 2", count); end
        checks++; if (reg_write_data !== 32'hA0) begin errors++; $display("FAIL bp_head_a: got %h want a0", reg_write_data); end
        rf_grant = 1'b1;
        @(negedge clk);
        rf_grant = 1'b0;
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL bp_after_grant_count: got %0d want 1", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_grant_ready: got %b want 1", in_ready); end
        checks++; if (reg_write_data !== 32'hB0) begin errors++; $display("FAIL bp_head_b: got %h want b0", reg_write_data); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_third_accepted: got %0d want 2", count); end
        rf_grant = 1'b1;
        @(negedge clk);
        checks++; if ({reg_rd, reg_write_data} !== {5'd4, 32'hC0}) begin errors++; $display("FAIL bp_head_c: got %0d/%h want 4/c0", reg_rd, reg_write_data); end
        @(negedge clk);
        rf_grant = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL bp_drained: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h1000, 32'h0, 5'd10);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h1000 + 32'(i), 32'h0, 5'(10 + i));
            rf_grant = 1'b1;
            @(negedge clk);
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, count); end
            checks++; if ({reg_rd, reg_write_data} !== {5'(10 + i), 32'h1000 + 32'(i)}) begin
                errors++; $display("FAIL b2b_head[%0d]: got %0d/%h want %0d/%h", i, reg_rd, reg_write_data, 10 + i, 32'h1000 + 32'(i));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        rf_grant = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
    endtask

    task automatic test_forward();
        drive_in(1'b1, WB_OUT, 1'b0, 3'b0, 2'd0, 32'h0, 32'h11, 5'd7);
        @(negedge clk);
        drive_in(1'b1, WB_OUT, 1'b0, 3'b0, 2'd0, 32'h0, 32'h22, 5'd7);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd0;
        #1;
        // 0x22 is still being accepted, so only 0x11 is visible.
        checks++; if ({fwd_hit1, fwd_data1} !== {FWD_ON, FWD_ON ? 32'h11 : 32'h0}) begin
            errors++; $display("FAIL fwd_accepting_invisible: got %b/%h", fwd_hit1, fwd_data1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if ({fwd_hit1, fwd_data1} !== {FWD_ON, FWD_ON ? 32'h22 : 32'h0}) begin
            errors++; $display("FAIL fwd_youngest: got %b/%h", fwd_hit1, fwd_data1);
        end
        checks++; if ({fwd_hit2, fwd_data2} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL fwd_rs_zero: got %b/%h want 0/0", fwd_hit2, fwd_data2);
        end
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd7;
        #1;
        checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", fwd_hit1); end
        checks++; if ({fwd_hit2, fwd_data2} !== {FWD_ON, FWD_ON ? 32'h22 : 32'h0}) begin
            errors++; $display("FAIL fwd_port2: got %b/%h", fwd_hit2, fwd_data2);
        end
        @(negedge clk);
        rf_grant = 1'b1;
        @(negedge clk);
        // The remaining entry is being popped this cycle and stays visible.
        #1;
        checks++; if ({fwd_hit2, fwd_data2} !== {FWD_ON, FWD_ON ? 32'h22 : 32'h0}) begin
            errors++; $display("FAIL fwd_popping_visible: got %b/%h", fwd_hit2, fwd_data2);
        end
        @(negedge clk);
        rf_grant = 1'b0;
        fwd_rs1  = 5'd0;
        fwd_rs2  = 5'd0;
        #1;
        checks++; if ({fwd_hit2, count} !== {1'b0, 2'd0}) begin errors++; $display("FAIL fwd_empty: got %b/%0d want 0/0", fwd_hit2, count); end
    endtask

    task automatic test_async_reset();
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h300, 32'h0, 5'd8);
        @(negedge clk);
        drive_in(1'b1, WB_PC, 1'b0, 3'b0, 2'd0, 32'h304, 32'h0, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset_pre_count: got %0d want 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (reg_op !== 1'b0) begin errors++; $display("FAIL areset_reg_op: got %b want 0", reg_op); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count); end
        checks++; if ({in_ready, reg_rd, reg_write_data} !== {1'b1, 5'd0, 32'h0}) begin
            errors++; $display("FAIL areset_outputs: got %b/%0d/%h want 1/0/0", in_ready, reg_rd, reg_write_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (reg_op !== 1'b0) begin errors++; $display("FAIL areset_after_release: got %b want 0", reg_op); end
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_pc_and_drop();
        test_back_pressure();
        test_back_to_back();
        test_forward();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
